// File: rtl/linkedlist_pkg.sv
// Shared definitions for the linked-list walker: node format, NIL pointer,
// theta range and the walker state encoding.
package linkedlist_pkg;

  localparam int THETA_W = 8;
  localparam int PTR_W   = 12;
  localparam int PAY_W   = 20;
  localparam int NODE_W  = 32;
  localparam int CNT_W   = 12;
  localparam int HOP_W   = 13;

  // Node word layout: {next[31:20], payload[19:0]}
  localparam int NEXT_LSB = 20;
  localparam int PAY_LSB  = 0;

  localparam logic [PTR_W-1:0]   NIL_PTR   = 12'hFFF;
  localparam logic [THETA_W-1:0] THETA_MAX = 8'd180;
  localparam logic [CNT_W-1:0]   CNT_MAX   = 12'hFFF;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HEAD_RD   = 3'd1,
    HEAD_WAIT = 3'd2,
    NODE_RD   = 3'd3,
    NODE_WAIT = 3'd4,
    EMIT      = 3'd5,
    DONE      = 3'd6
  } state_e;

  function automatic logic [PTR_W-1:0] node_next(input logic [NODE_W-1:0] node);
    return node[NEXT_LSB +: PTR_W];
  endfunction

  function automatic logic [PAY_W-1:0] node_payload(input logic [NODE_W-1:0] node);
    return node[PAY_LSB +: PAY_W];
  endfunction

endpackage

// File: rtl/linkedlist_walker.sv
// Walks a singly linked list stored in an external parameter SRAM, starting
// from the head pointer read from an external head SRAM indexed by theta.
// Both SRAMs are synchronous read (data one cycle after the address).
// Payload beats leave on a valid/ready port: node_data_o is held stable while
// node_valid_o is high, and a beat transfers on a cycle where both node_valid_o
// and node_ready_i are high at the rising clock edge.
// Optional feature: define LINKEDLIST_WALKER_LOOPGUARD_EN to add a hop counter
// that aborts a walk (err_o=1) on its 4096th node read, breaking cyclic lists.
module linkedlist_walker
  import linkedlist_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               start_i,
  input  logic [THETA_W-1:0] theta_i,
  output logic               busy_o,
  output logic [THETA_W-1:0] theta_addr_o,
  input  logic [PTR_W-1:0]   head_i,
  output logic [PTR_W-1:0]   param_addr_o,
  input  logic [NODE_W-1:0]  node_i,
  output logic               node_valid_o,
  input  logic               node_ready_i,
  output logic [PAY_W-1:0]   node_data_o,
  output logic               done_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               err_o,
  output state_e             state_o
);

  state_e           state;
  logic [PTR_W-1:0] next_q;

`ifdef LINKEDLIST_WALKER_LOOPGUARD_EN
  logic [HOP_W-1:0] hops;
`endif

  // Busy in every state except IDLE; decoded straight from the state flop.
  assign busy_o  = (state != IDLE);
  assign state_o = state;

  // Walker FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      next_q       <= NIL_PTR;
      theta_addr_o <= '0;
      param_addr_o <= '0;
      node_valid_o <= 1'b0;
      node_data_o  <= '0;
      done_o       <= 1'b0;
      count_o      <= '0;
      err_o        <= 1'b0;
`ifdef LINKEDLIST_WALKER_LOOPGUARD_EN
      hops         <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            count_o <= '0;
            err_o   <= 1'b0;
`ifdef LINKEDLIST_WALKER_LOOPGUARD_EN
            hops    <= '0;
`endif
            if (theta_i > THETA_MAX) begin
              // Out-of-range bin: finish at once without touching the SRAMs.
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              theta_addr_o <= theta_i;
              state        <= HEAD_RD;
            end
          end
        end
        HEAD_RD: state <= HEAD_WAIT;
        HEAD_WAIT: begin
          if (head_i == NIL_PTR) begin
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            param_addr_o <= head_i;
            state        <= NODE_RD;
          end
        end
        NODE_RD: begin
`ifdef LINKEDLIST_WALKER_LOOPGUARD_EN
          // 4095 earlier node reads means this is the 4096th: treat as a loop.
          if (hops == HOP_W'(4095)) begin
            err_o  <= 1'b1;
            done_o <= 1'b1;
            state  <= DONE;
          end else begin
            hops  <= hops + 1'b1;
            state <= NODE_WAIT;
          end
`else
          state <= NODE_WAIT;
`endif
        end
        NODE_WAIT: begin
          node_data_o  <= node_payload(node_i);
          next_q       <= node_next(node_i);
          node_valid_o <= 1'b1;
          state        <= EMIT;
        end
        EMIT: begin
          if (node_ready_i) begin
            node_valid_o <= 1'b0;
            if (count_o != CNT_MAX) count_o <= count_o + 1'b1;
            if (next_q == NIL_PTR) begin
              done_o <= 1'b1;
              state  <= DONE;
            end else begin
              param_addr_o <= next_q;
              state        <= NODE_RD;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
